// File: rtl/udp_packet_fifo_pkg.sv
// Shared types and constants for the UDP packet FIFO: packet layout, storage entry and write FSM.
package udp_pkt_pkg;

  localparam int unsigned HDR_WORDS   = 3;
  localparam int unsigned CH_WORDS    = 160;
  localparam int unsigned RECON_WORDS = 4;
  localparam int unsigned PKT_WORDS   = HDR_WORDS + CH_WORDS + RECON_WORDS;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } pkt_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDiscard
  } wr_state_e;

endpackage

// File: rtl/udp_packet_fifo_if.sv
// Packet stream bundle (32-bit data, sop/eop delimiters, ready/valid handshake).
interface udp_packet_fifo_if;
  logic [31:0] data;
  logic        valid;
  logic        ready;
  logic [1:0]  empty;
  logic        startofpacket;
  logic        endofpacket;

  modport master (output data, valid, empty, startofpacket, endofpacket, input ready);
  modport slave  (input data, valid, empty, startofpacket, endofpacket, output ready);
endinterface

// File: rtl/udp_packet_fifo_pkt_ram.sv
// Simple dual-port packet storage, DEPTH x 34 bits, registered read, array not reset.
module pkt_ram
  import udp_pkt_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  pkt_entry_t        i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output pkt_entry_t        o_rdata
);

  pkt_entry_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/udp_packet_fifo.sv
// Store-and-forward packet buffer: commits whole packets only, drops packets that do not fit.
// Define UDP_PKT_LEN_CHECK_EN to also drop packets whose length differs from PKT_WORDS.
module udp_packet_fifo
  import udp_pkt_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned PKT_WORDS = udp_pkt_pkg::PKT_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  udp_packet_fifo_if.slave  data_in,
  udp_packet_fifo_if.master to_udp,
  output logic [15:0]       pkt_count,
  output logic [15:0]       drop_count,
  output logic [ADDR_W:0]   fill_level
);

  typedef logic [ADDR_W:0] ptr_t;
  localparam ptr_t DepthPtr = ptr_t'(DEPTH);

  wr_state_e   r_state, w_state_nxt;
  ptr_t        r_wr_ptr, r_commit_ptr, r_rd_ptr, w_wr_nxt, w_commit_nxt;
  logic [15:0] r_pkt_cnt, r_drop_cnt;
  logic [16:0] w_drop_sum;
  logic [1:0]  w_drop_inc;
  logic        r_in_rdy, r_q_vld, r_skid_vld;
  pkt_entry_t  r_skid, w_q, w_wdata, w_out;
  logic        w_acc, w_full_cm, w_full_wr, w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic        w_len_over, w_len_ok_one, w_len_ok_fill;
  logic        w_out_vld, w_pop, w_rd_en, w_q_take, w_q_move;
  logic        w_unused;

  assign w_unused  = ^data_in.empty;
  assign w_acc     = data_in.valid && r_in_rdy;
  assign w_wdata   = '{sop: data_in.startofpacket, eop: data_in.endofpacket, data: data_in.data};
  assign w_full_cm = (r_commit_ptr - r_rd_ptr) == DepthPtr;
  assign w_full_wr = (r_wr_ptr - r_rd_ptr) == DepthPtr;

`ifdef UDP_PKT_LEN_CHECK_EN
  logic [15:0] r_len, w_len_nxt;
  assign w_len_over    = r_len >= 16'(PKT_WORDS);
  assign w_len_ok_one  = (PKT_WORDS == 1);
  assign w_len_ok_fill = (r_len + 16'd1) == 16'(PKT_WORDS);
  always_ff @(posedge clk) begin
    if (!rst) r_len <= '0;
    else      r_len <= w_len_nxt;
  end
`else
  assign w_len_over    = 1'b0;
  assign w_len_ok_one  = 1'b1;
  assign w_len_ok_fill = 1'b1;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_nxt     = r_wr_ptr;
    w_commit_nxt = r_commit_ptr;
    w_drop_inc   = 2'd0;
    w_we         = 1'b0;
    w_waddr      = r_wr_ptr[ADDR_W-1:0];
`ifdef UDP_PKT_LEN_CHECK_EN
    w_len_nxt    = r_len;
`endif
    if (w_acc && data_in.startofpacket) begin
      // A sop always restarts at commit_ptr; any partial packet in progress is abandoned.
      if (r_state != StIdle) w_drop_inc = 2'd1;
      w_waddr  = r_commit_ptr[ADDR_W-1:0];
      w_wr_nxt = r_commit_ptr;
      if (w_full_cm) begin
        if (data_in.endofpacket) begin
          w_drop_inc  = w_drop_inc + 2'd1;
          w_state_nxt = StIdle;
        end else begin
          w_state_nxt = StDiscard;
        end
      end else begin
        w_we = 1'b1;
`ifdef UDP_PKT_LEN_CHECK_EN
        w_len_nxt = 16'd1;
`endif
        if (data_in.endofpacket) begin
          w_state_nxt = StIdle;
          if (w_len_ok_one) begin
            w_wr_nxt     = r_commit_ptr + ptr_t'(1);
            w_commit_nxt = r_commit_ptr + ptr_t'(1);
          end else begin
            w_drop_inc = w_drop_inc + 2'd1;
          end
        end else begin
          w_wr_nxt    = r_commit_ptr + ptr_t'(1);
          w_state_nxt = StFill;
        end
      end
    end else if (w_acc) begin
      unique case (r_state)
        StFill: begin
          if (w_full_wr || w_len_over) begin
            if (data_in.endofpacket) begin
              w_wr_nxt    = r_commit_ptr;
              w_drop_inc  = 2'd1;
              w_state_nxt = StIdle;
            end else begin
              w_state_nxt = StDiscard;
            end
          end else begin
            w_we     = 1'b1;
            w_wr_nxt = r_wr_ptr + ptr_t'(1);
`ifdef UDP_PKT_LEN_CHECK_EN
            w_len_nxt = r_len + 16'd1;
`endif
            if (data_in.endofpacket) begin
              w_state_nxt = StIdle;
              if (w_len_ok_fill) begin
                w_commit_nxt = r_wr_ptr + ptr_t'(1);
              end else begin
                w_wr_nxt   = r_commit_ptr;
                w_drop_inc = 2'd1;
              end
            end
          end
        end
        StDiscard: begin
          if (data_in.endofpacket) begin
            w_wr_nxt    = r_commit_ptr;
            w_drop_inc  = 2'd1;
            w_state_nxt = StIdle;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + {15'd0, w_drop_inc};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_ptr     <= w_wr_nxt;
      r_commit_ptr <= w_commit_nxt;
      r_drop_cnt   <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  pkt_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata (w_q)
  );

  // The RAM output register is the first skid entry; r_skid holds the older word when stalled.
  assign w_out_vld = r_skid_vld || r_q_vld;
  assign w_out     = r_skid_vld ? r_skid : (r_q_vld ? w_q : '0);
  assign w_pop     = w_out_vld && to_udp.ready;
  assign w_rd_en   = (r_rd_ptr != r_commit_ptr) && !(r_skid_vld && r_q_vld && !w_pop);
  assign w_q_take  = r_q_vld && !r_skid_vld && w_pop;
  assign w_q_move  = r_q_vld && w_rd_en && !w_q_take;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr   <= '0;
      r_q_vld    <= 1'b0;
      r_skid_vld <= 1'b0;
      r_skid     <= '0;
      r_pkt_cnt  <= '0;
      r_in_rdy   <= 1'b0;
    end else begin
      r_in_rdy   <= 1'b1;
      r_q_vld    <= w_rd_en || (r_q_vld && !w_q_take);
      r_skid_vld <= (r_skid_vld && !w_pop) || w_q_move;
      if (w_rd_en)          r_rd_ptr  <= r_rd_ptr + ptr_t'(1);
      if (w_q_move)         r_skid    <= w_q;
      if (w_pop && w_out.eop) r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

  assign to_udp.valid         = w_out_vld;
  assign to_udp.data          = w_out.data;
  assign to_udp.startofpacket = w_out.sop;
  assign to_udp.endofpacket   = w_out.eop;
  assign to_udp.empty         = 2'b00;
  assign data_in.ready        = r_in_rdy;
  assign pkt_count            = r_pkt_cnt;
  assign drop_count           = r_drop_cnt;
  assign fill_level           = (r_commit_ptr - r_rd_ptr) + ptr_t'(r_q_vld) + ptr_t'(r_skid_vld);

endmodule

// File: tb/tb_udp_packet_fifo.sv
// Self-checking bench for udp_packet_fifo: vector table of packets plus hand-written corner sequences.
module tb_udp_packet_fifo;
  import udp_pkt_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pkt_count, drop_count;
  logic [10:0] fill_level;

  udp_packet_fifo_if in_if ();
  udp_packet_fifo_if out_if ();

  udp_packet_fifo #(
    .DEPTH     (1024),
    .ADDR_W    (10),
    .PKT_WORDS (167)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (in_if),
    .to_udp     (out_if),
    .pkt_count  (pkt_count),
    .drop_count (drop_count),
    .fill_level (fill_level)
  );

`ifdef UDP_PKT_LEN_CHECK_EN
  localparam bit LenChk = 1'b1;
`else
  localparam bit LenChk = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0, errors = 0;
  int rdy_mode = 1;  // 0 low, 1 high, 2 random
  int pid = 0, t_eop = 0, e_pkt = 0, e_drop = 0;
  pkt_entry_t sb[$];
  bit          prev_stall = 1'b0;
  logic [33:0] prev_word;

  typedef struct {
    int len;
    int rmode;
    bit fwd;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    out_if.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 2) out_if.ready = 1'($urandom_range(0, 1));
      else               out_if.ready = (rdy_mode == 1);
    end
  end

  // Output monitor: stall stability and scoreboard comparison on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", 64'({out_if.valid, out_if.startofpacket, out_if.endofpacket,
                               out_if.data}), 64'({1'b1, prev_word}));
      if (out_if.valid && out_if.ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h, want none", out_if.data);
        end else begin
          chk("out_word", 64'({out_if.startofpacket, out_if.endofpacket, out_if.data}),
              64'(sb.pop_front()));
        end
      end
      prev_stall = out_if.valid && !out_if.ready;
      prev_word  = {out_if.startofpacket, out_if.endofpacket, out_if.data};
    end
  end

  task automatic send_pkt(input int len, input bit has_eop, input bit fwd);
    pkt_entry_t pk[$];
    for (int i = 0; i < len; i++) begin
      in_if.valid         = 1'b1;
      in_if.data          = {pid[15:0], i[15:0]};
      in_if.startofpacket = (i == 0);
      in_if.endofpacket   = has_eop && (i == len - 1);
      pk.push_back('{sop: in_if.startofpacket, eop: in_if.endofpacket, data: in_if.data});
      if (in_if.endofpacket) t_eop = cyc;
      @(posedge clk); #1;
    end
    in_if.valid         = 1'b0;
    in_if.startofpacket = 1'b0;
    in_if.endofpacket   = 1'b0;
    if (fwd && has_eop) foreach (pk[k]) sb.push_back(pk[k]);
    pid++;
  endtask

  task automatic drain(input int mode);
    int c = 0;
    rdy_mode = mode;
    while ((sb.size() != 0 || out_if.valid) && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
    rdy_mode = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_counts(input string tag, input int fill);
    chk({tag, "_pkt_count"}, 64'(pkt_count), 64'(e_pkt));
    chk({tag, "_drop_count"}, 64'(drop_count), 64'(e_drop));
    chk({tag, "_fill_level"}, 64'(fill_level), 64'(fill));
  endtask

  initial begin
    int lat;
    rst                 = 1'b0;
    in_if.valid         = 1'b0;
    in_if.data          = '0;
    in_if.empty         = 2'b00;
    in_if.startofpacket = 1'b0;
    in_if.endofpacket   = 1'b0;

    vecs[0] = '{167, 1, 1'b1};
    vecs[1] = '{1,   1, !LenChk};
    vecs[2] = '{166, 2, !LenChk};
    vecs[3] = '{168, 1, !LenChk};
    vecs[4] = '{167, 2, 1'b1};
    vecs[5] = '{50,  2, !LenChk};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_to_udp", 64'({out_if.valid, out_if.startofpacket, out_if.endofpacket,
                          out_if.data, out_if.empty}), 64'd0);
    chk("rst_in_ready", 64'(in_if.ready), 64'd0);
    check_counts("rst", 0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("in_ready", 64'(in_if.ready), 64'd1);
    @(posedge clk); #1;

    // First valid two cycles after the eop cycle
    send_pkt(167, 1'b1, 1'b1);
    e_pkt++;
    lat = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_if.valid) begin
        lat = cyc - t_eop;
        break;
      end
    end
    chk("first_latency", 64'(lat), 64'd2);
    chk("first_sop", 64'(out_if.startofpacket), 64'd1);
    drain(1);
    check_counts("single", 0);

    for (int v = 0; v < 6; v++) begin
      rdy_mode = vecs[v].rmode;
      send_pkt(vecs[v].len, 1'b1, vecs[v].fwd);
      if (vecs[v].fwd) e_pkt++;
      else             e_drop++;
      drain(vecs[v].rmode);
      check_counts($sformatf("vec%0d", v), 0);
    end

    // Stray words without sop are silently ignored
    for (int i = 0; i < 3; i++) begin
      in_if.valid       = 1'b1;
      in_if.data        = 32'hDEAD_0000 + i;
      in_if.endofpacket = (i == 2);
      @(posedge clk); #1;
    end
    in_if.valid       = 1'b0;
    in_if.endofpacket = 1'b0;
    drain(1);
    check_counts("stray", 0);

    // Four packets buffered with ready low
    rdy_mode = 0;
    for (int p = 0; p < 4; p++) send_pkt(167, 1'b1, 1'b1);
    e_pkt += 4;
    @(negedge clk);
    chk("four_fill", 64'(fill_level), 64'd668);
    chk("four_hold_sop", 64'({out_if.valid, out_if.startofpacket}), 64'd3);
    drain(1);
    check_counts("four", 0);

    // Seventh packet overflows and is dropped whole
    rdy_mode = 0;
    for (int p = 0; p < 6; p++) send_pkt(167, 1'b1, 1'b1);
    send_pkt(167, 1'b1, 1'b0);
    e_pkt += 6;
    e_drop++;
    @(negedge clk);
    chk("seven_fill", 64'(fill_level), 64'd1002);
    chk("seven_drop", 64'(drop_count), 64'(e_drop));
    drain(2);
    send_pkt(167, 1'b1, 1'b1);
    e_pkt++;
    drain(1);
    check_counts("seven", 0);

    // sop at word 50 abandons the first packet
    send_pkt(50, 1'b0, 1'b0);
    send_pkt(167, 1'b1, 1'b1);
    e_drop++;
    e_pkt++;
    drain(2);
    check_counts("sop_cut", 0);

    // Reset with a partial packet in flight
    send_pkt(30, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    e_pkt  = 0;
    e_drop = 0;
    chk("mid_rst_in_ready", 64'(in_if.ready), 64'd0);
    check_counts("mid_rst", 0);
    rst = 1'b1;
    @(posedge clk); #1;
    send_pkt(167, 1'b1, 1'b1);
    e_pkt++;
    drain(1);
    check_counts("post_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
